// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
//   rf_state_e   : array-clear FSM state (RF_CLEAR sweeps the array, RF_READY serves traffic)
//   RF_ZERO_ADDR : index of the hardwired-zero register
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int unsigned RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for the out-of-order write-back path.
// Ports:
//   clk, rst        clock / async active-high reset (clears all busy bits)
//   en_i            array is READY; sets/clears are ignored otherwise
//   flush_i         clear every busy bit at the next edge
//   sb_set_en_i     mark sb_set_addr_i busy
//   sb_set_addr_i   register being claimed by a new producer
//   wr_en_i/addr_i  write-back ports; each enabled write retires its register
//   rd_en_i/addr_i  read ports
//   rd_busy_o       busy bit of each read address, masked by same-cycle write-back
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    sb_set_en_i,
  input  logic [AW-1:0]           sb_set_addr_i,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
  input  logic [NRD-1:0]          rd_en_i,
  input  logic [NRD-1:0][AW-1:0]  rd_addr_i,
  output logic [NRD-1:0]          rd_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Retire first, then claim, so a new producer overrides a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else if (en_i) begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en_i[w]) busy_d[wr_addr_i[w]] = 1'b0;
      end
      if (sb_set_en_i) busy_d[sb_set_addr_i] = 1'b1;
    end
    busy_d[RF_ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // A write-back landing this cycle is already visible through the data bypass,
  // so the register must not look busy to the reader.
  always_comb begin
    rd_busy_o = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (en_i && rd_en_i[p] && (rd_addr_i[p] != AW'(RF_ZERO_ADDR))) begin
        rd_busy_o[p] = busy_q[rd_addr_i[p]];
        for (int unsigned w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[p])) rd_busy_o[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file (ID/WB stages) with write-to-read bypass,
// fixed-priority write ports and a post-reset/flush clear sweep so the storage
// itself carries no reset and can map to RAM/LUTRAM.
// Optional feature macro: REGFILE_SCOREBOARD_EN enables the busy scoreboard.
// Ports:
//   clk, rst              clock / async active-high reset
//   clr_req               flush request, accepted only when ready
//   ready                 1 = array valid, 0 = clear sweep in progress
//   rd_en/rd_addr         read ports; rd_data, rd_busy are combinational
//   wr_en/wr_addr/wr_data write ports, higher index wins
//   sb_set_en/sb_set_addr scoreboard claim (ignored without the scoreboard)
//   wr_conflict           registered: two enabled writes shared an address last cycle
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  output logic                    ready,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                    sb_set_en,
  input  logic [AW-1:0]           sb_set_addr,
  output logic                    wr_conflict
);

  rf_state_e        state_q;
  logic [AW-1:0]    idx_q;
  logic             ready_q;
  logic             wr_conflict_q;
  logic             conflict_c;
  logic [XLEN-1:0]  regs_q [NREGS];

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

  // Any pair of enabled write ports on one address, register 0 included.
  always_comb begin
    conflict_c = 1'b0;
    for (int unsigned i = 0; i < NWR; i++) begin
      for (int unsigned j = i + 1; j < NWR; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j])) conflict_c = 1'b1;
      end
    end
  end

  // Clear-sweep FSM; ready_q mirrors RF_READY as a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RF_CLEAR;
      idx_q         <= '0;
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= ready_q & conflict_c;
      case (state_q)
        RF_CLEAR: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(NREGS - 1)) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        RF_READY: begin
          if (clr_req) begin
            state_q <= RF_CLEAR;
            ready_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          ready_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Storage without reset; ascending port order lets the highest index win.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      regs_q[idx_q] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w] != AW'(RF_ZERO_ADDR))) regs_q[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  // Read with same-cycle bypass; highest-index matching writer wins.
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (ready_q && rd_en[p] && (rd_addr[p] != AW'(RF_ZERO_ADDR))) begin
        rd_data[p] = regs_q[rd_addr[p]];
        for (int unsigned w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[p])) rd_data[p] = wr_data[w];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .en_i          (ready_q),
    .flush_i       (ready_q & clr_req),
    .sb_set_en_i   (sb_set_en),
    .sb_set_addr_i (sb_set_addr),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_busy_o     (rd_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_en, sb_set_addr};
  assign rd_busy   = '0;
`endif

endmodule
